// File: rtl/mem_ctrl_burst.sv
// Burst memory controller: arbitrates IF fetches and MEM loads/stores onto one
// byte-wide synchronous RAM port, serialising little-endian multi-byte transfers.
module mem_ctrl_burst #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_BYTES = 4,
  parameter int LEN_WIDTH  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  input  logic                    if_flush,
  output logic [8*DATA_BYTES-1:0] if_data,
  output logic                    if_done,
  input  logic [1:0]              mem_req,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [LEN_WIDTH-1:0]    mem_len,
  input  logic [8*DATA_BYTES-1:0] mem_wdata,
  output logic [8*DATA_BYTES-1:0] mem_rdata,
  output logic                    mem_done,
  output logic                    busy,
  input  logic [7:0]              ram_data_i,
  output logic [7:0]              ram_data_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_rw
);

  localparam int CNT_W = LEN_WIDTH + 1;
  localparam int DW    = 8 * DATA_BYTES;
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(DATA_BYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic                  src_if_q, src_if_d;
  logic [DW-1:0]         if_data_q, if_data_d;
  logic [DW-1:0]         mem_rdata_q, mem_rdata_d;
  logic                  if_done_q, if_done_d;
  logic                  mem_done_q, mem_done_d;
  logic                  busy_q, busy_d;
  logic [7:0]            ram_data_q, ram_data_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                  ram_rw_q, ram_rw_d;

  logic                  mem_ld_s;
  logic                  mem_st_s;
  logic                  if_go_s;
  logic                  can_accept_s;
  logic [CNT_W-1:0]      len_ext_s;
  logic [DW-1:0]         rd_cur_s;
  logic [DW-1:0]         rd_new_s;

  function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] l);
    logic [LEN_WIDTH-1:0] r;
    if (l == '0) begin
      r = LEN_WIDTH'(1);
    end else if (l > LEN_MAX) begin
      r = LEN_MAX;
    end else begin
      r = l;
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] put_byte(input logic [DW-1:0] w,
                                             input logic [CNT_W-1:0] idx,
                                             input logic [7:0] b);
    logic [DW-1:0] r;
    for (int i = 0; i < DATA_BYTES; i++) begin
      r[8*i +: 8] = (idx == CNT_W'(i)) ? b : w[8*i +: 8];
    end
    return r;
  endfunction

  function automatic logic [7:0] get_byte(input logic [DW-1:0] w,
                                          input logic [CNT_W-1:0] idx);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < DATA_BYTES; i++) begin
      r = (idx == CNT_W'(i)) ? w[8*i +: 8] : r;
    end
    return r;
  endfunction

  assign mem_ld_s     = (mem_req == 2'b01);
  assign mem_st_s     = (mem_req == 2'b10);
  assign if_go_s      = if_req && !if_flush;
  // A done pulse in flight means the requester has not yet dropped its level request.
  assign can_accept_s = !if_done_q && !mem_done_q;
  assign len_ext_s    = {1'b0, len_q};
  assign rd_cur_s     = src_if_q ? if_data_q : mem_rdata_q;
  // cnt_q counts edges since accept; the byte landing now was addressed two edges ago.
  assign rd_new_s     = put_byte(rd_cur_s, cnt_q - CNT_W'(2), ram_data_i);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    src_if_d    = src_if_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    ram_addr_d  = '0;
    ram_data_d  = 8'h00;
    ram_rw_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (can_accept_s && (mem_ld_s || mem_st_s)) begin
          state_d     = mem_st_s ? S_WRITE : S_READ;
          base_d      = mem_addr;
          len_d       = clamp_len(mem_len);
          wdata_d     = mem_wdata;
          src_if_d    = 1'b0;
          cnt_d       = CNT_W'(1);
          mem_rdata_d = mem_ld_s ? '0 : mem_rdata_q;
          ram_addr_d  = mem_addr;
          ram_rw_d    = mem_st_s;
          ram_data_d  = mem_st_s ? mem_wdata[7:0] : 8'h00;
        end else if (can_accept_s && if_go_s) begin
          state_d    = S_READ;
          base_d     = if_addr;
          len_d      = LEN_MAX;
          wdata_d    = '0;
          src_if_d   = 1'b1;
          cnt_d      = CNT_W'(1);
          if_data_d  = '0;
          ram_addr_d = if_addr;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_READ: begin
        cnt_d      = cnt_q + CNT_W'(1);
        ram_addr_d = (cnt_q < len_ext_s) ? (base_q + ADDR_WIDTH'(cnt_q)) : '0;
        if (cnt_q >= CNT_W'(2)) begin
          if_data_d   = src_if_q ? rd_new_s : if_data_q;
          mem_rdata_d = src_if_q ? mem_rdata_q : rd_new_s;
        end else begin
          if_data_d   = if_data_q;
          mem_rdata_d = mem_rdata_q;
        end
        if (src_if_q && if_flush) begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          ram_addr_d = '0;
        end else if (cnt_q == (len_ext_s + CNT_W'(1))) begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          if_done_d  = src_if_q;
          mem_done_d = !src_if_q;
        end else begin
          state_d = S_READ;
        end
      end

      S_WRITE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q < len_ext_s) begin
          state_d    = S_WRITE;
          ram_addr_d = base_q + ADDR_WIDTH'(cnt_q);
          ram_data_d = get_byte(wdata_q, cnt_q);
          ram_rw_d   = 1'b1;
        end else begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          mem_done_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      src_if_q    <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      ram_data_q  <= 8'h00;
      ram_addr_q  <= '0;
      ram_rw_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      src_if_q    <= src_if_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      busy_q      <= busy_d;
      ram_data_q  <= ram_data_d;
      ram_addr_q  <= ram_addr_d;
      ram_rw_q    <= ram_rw_d;
    end
  end

  assign if_data    = if_data_q;
  assign if_done    = if_done_q;
  assign mem_rdata  = mem_rdata_q;
  assign mem_done   = mem_done_q;
  assign busy       = busy_q;
  assign ram_data_o = ram_data_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_rw     = ram_rw_q;

endmodule

// File: doc/mem_ctrl_burst.md
Name: mem_ctrl_burst

Overview:
- Sequential successor to the single-byte combinational memory arbiter.
- Arbitrates instruction fetch (IF) and load/store (MEM) requests onto the single byte-wide synchronous RAM port.
- Serialises multi-byte transfers of up to DATA_BYTES bytes in little-endian order and returns assembled words with one-cycle done pulses.
- Sits between the IF/MEM stages and the RAM.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_BYTES, 4, maximum bytes per transfer; IF always fetches DATA_BYTES bytes.
- LEN_WIDTH, 3, width of mem_len; must hold the value DATA_BYTES.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- if_req  in  1  level request: fetch DATA_BYTES bytes at if_addr.
- if_addr  in  ADDR_WIDTH  fetch base address.
- if_flush  in  1  cancel any pending or in-flight IF fetch.
- if_data  out  8*DATA_BYTES  fetched word; byte i at bits [8i+7:8i].
- if_done  out  1  one-cycle pulse: if_data valid.
- mem_req  in  2  00 none, 01 load, 10 store, 11 treated as none.
- mem_addr  in  ADDR_WIDTH  load/store base address.
- mem_len  in  LEN_WIDTH  byte count 1..DATA_BYTES; 0 treated as 1; values >DATA_BYTES clamp to DATA_BYTES.
- mem_wdata  in  8*DATA_BYTES  store data; byte i at bits [8i+7:8i].
- mem_rdata  out  8*DATA_BYTES  load result; unread upper bytes are 0.
- mem_done  out  1  one-cycle pulse: load data valid or store complete.
- busy  out  1  high while state is not IDLE.
- ram_data_i  in  8  RAM read data; valid the cycle after its address is presented.
- ram_data_o  out  8  RAM write data.
- ram_addr_o  out  ADDR_WIDTH  RAM address.
- ram_rw  out  1  0 read, 1 write.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; internal counters, latched address, data and length cleared. Any in-flight transfer is abandoned with no done pulse.
- States: IDLE, READ, WRITE.
- Acceptance in IDLE at a rising edge:
  - No acceptance in any cycle where if_done or mem_done is high; this prevents re-accepting a stale level request.
  - Priority: mem load/store over if_req.
  - if_req is ignored while if_flush is high.
  - On accept, latch base address, length N (IF: DATA_BYTES), mem_wdata and requester id; clear byte counter; clear the destination data register.
- Transfers are never preempted except IF by if_flush.
- READ, with accept edge k:
  - In the cycle after edge k+i (i < N): ram_addr_o = base+i, ram_rw=0.
  - Byte i is captured from ram_data_i at edge k+i+2.
  - At edge k+N+1: last byte captured, done pulse set, return to IDLE.
  - Latency: done high in the cycle after edge k+N+1.
  - After the last address cycle, ram_addr_o=0 while waiting.
- WRITE:
  - In the cycle after edge k+i (i < N): ram_addr_o = base+i, ram_data_o = byte i, ram_rw=1.
  - At edge k+N: mem_done set, return to IDLE.
- Idle and outside active cycles: ram_addr_o=0, ram_data_o=0, ram_rw=0.
- Address arithmetic is modulo 2^ADDR_WIDTH; base+i wraps through 0.
- Done pulses:
  - if_done and mem_done are exactly one cycle and never both high.
  - if_data and mem_rdata hold their value until the next accepted transfer of the same requester.
- if_flush:
  - Sampled high during an IF READ: return to IDLE at that edge; no if_done; if_data contents undefined until the next fetch.
  - No effect on MEM transfers.
- A requester must keep its request stable until its done pulse. Changes to address or data after acceptance are ignored.

Test Plan:
- Load 4 bytes: mem_req=01, mem_addr=0x100, mem_len=4, RAM holds 11,22,33,44 at 0x100..0x103 -> addresses 0x100..0x103 on consecutive cycles; mem_done in cycle 5 after accept edge; mem_rdata=0x44332211.
- Store 2 bytes: mem_req=10, addr=0x200, len=2, wdata=0xDEADBEEF -> ram_rw=1 for exactly 2 cycles with (0x200,EF),(0x201,BE); mem_done 2 cycles after accept; RAM 0x202 untouched.
- Simultaneous requests: if_req=1 at 0x0 and mem_req=01 at 0x40 in the same cycle -> MEM load served first; after mem_done plus one blocked cycle, IF fetch of 0x0..0x3 proceeds; if_done once.
- Flush: IF fetch at 0x10, if_flush high 2 cycles after accept -> return to IDLE next edge; no if_done; ram_rw stays 0; a new fetch is then accepted normally.
- Wrap and edge lengths: load len=0 at 0xFFFFFFFF -> 1 byte read, mem_rdata upper bytes 0; fetch at 0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 0, 1.
- Reset mid-store: assert rst after 1 of 4 write cycles -> all outputs 0 immediately, no mem_done; after release, controller is IDLE and accepts a new request.
